// File: rtl/user_clock_switch_sequencer.sv
// Control-side sequencer for an N-input glitchless clock selector.
// Drives one-hot clock-buffer enables with break-before-make timing and optional auto-fallback.
module user_clock_switch_sequencer #(
    parameter int unsigned NUM_CLKS      = 4,
    parameter int unsigned SEL_W         = 2,
    parameter int unsigned OFF_CYCLES    = 8,
    parameter int unsigned ON_CYCLES     = 8,
    parameter int unsigned DEFAULT_SEL   = 0,
    parameter int unsigned AUTO_FALLBACK = 1
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [SEL_W-1:0]    sel_req,
    input  logic                sel_valid,
    output logic                sel_ready,
    input  logic [NUM_CLKS-1:0] clk_present,
    output logic [NUM_CLKS-1:0] clk_en,
    output logic [SEL_W-1:0]    active_sel,
    output logic                switching,
    output logic                done,
    output logic                err_invalid,
    output logic                fallback
);

    localparam int unsigned      CNT_MAX  = (OFF_CYCLES > ON_CYCLES) ? OFF_CYCLES : ON_CYCLES;
    localparam int unsigned      CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [SEL_W-1:0] DEF_IDX  = SEL_W'(DEFAULT_SEL);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DISABLE = 2'd1,
        ST_ENABLE  = 2'd2
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [SEL_W-1:0]    r_target;
    logic [SEL_W-1:0]    r_active;
    logic [NUM_CLKS-1:0] r_clk_en;
    logic                r_sel_ready;
    logic                r_switching;
    logic                r_done;
    logic                r_err;
    logic                r_fb;

    state_t              w_state_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [SEL_W-1:0]    w_target_nxt;
    logic [SEL_W-1:0]    w_active_nxt;
    logic [NUM_CLKS-1:0] w_clk_en_nxt;
    logic                w_done_nxt;
    logic                w_req_present;
    logic                w_act_present;
    logic                w_other_present;
    logic [SEL_W-1:0]    w_fb_idx;
    logic                w_fb_cond;
    logic                w_accept;
    logic                w_start_fb;
    logic                w_req_err;
    logic                w_req_noop;

    function automatic logic [NUM_CLKS-1:0] f_onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_CLKS-1:0] v;
        v = '0;
        for (int i = 0; i < int'(NUM_CLKS); i++) begin
            if (SEL_W'(i) == idx) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    // Channel liveness lookups; out-of-range requests never match and read as absent.
    // Descending scan so the lowest-index live alternative wins the fallback choice.
    always_comb begin
        w_req_present   = 1'b0;
        w_act_present   = 1'b0;
        w_other_present = 1'b0;
        w_fb_idx        = r_active;
        for (int i = int'(NUM_CLKS) - 1; i >= 0; i--) begin
            if (SEL_W'(i) == sel_req) begin
                w_req_present = clk_present[i];
            end
            if (SEL_W'(i) == r_active) begin
                w_act_present = clk_present[i];
            end else if (clk_present[i]) begin
                w_other_present = 1'b1;
                w_fb_idx        = SEL_W'(i);
            end
        end
    end

    // Fallback outranks a simultaneous request, which then stays pending.
    assign w_fb_cond = (AUTO_FALLBACK != 0) && (r_state == ST_IDLE)
                       && !w_act_present && w_other_present;
    assign w_accept  = (r_state == ST_IDLE) && r_sel_ready && sel_valid && !w_fb_cond;

    // State and datapath registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state  <= ST_DISABLE;
            r_cnt    <= '0;
            r_target <= DEF_IDX;
            r_active <= DEF_IDX;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_target <= w_target_nxt;
            r_active <= w_active_nxt;
        end
    end

    // Next-state logic; the counter restarts on every state entry.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt + CNT_W'(1);
        w_target_nxt = r_target;
        w_start_fb   = 1'b0;
        w_req_err    = 1'b0;
        w_req_noop   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (w_fb_cond) begin
                    w_target_nxt = w_fb_idx;
                    w_state_nxt  = ST_DISABLE;
                    w_start_fb   = 1'b1;
                end else if (w_accept) begin
                    if (!w_req_present) begin
                        w_req_err = 1'b1;
                    end else if (sel_req == r_active) begin
                        w_req_noop = 1'b1;
                    end else begin
                        w_target_nxt = sel_req;
                        w_state_nxt  = ST_DISABLE;
                    end
                end
            end
            ST_DISABLE: begin
                if (r_cnt == OFF_LAST) begin
                    w_state_nxt = ST_ENABLE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_ENABLE: begin
                if (r_cnt == ON_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_DISABLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode from the next state, so every output leaves a flop.
    always_comb begin
        w_active_nxt = r_active;
        if (w_state_nxt == ST_ENABLE) begin
            w_active_nxt = r_target;
        end
        w_clk_en_nxt = (w_state_nxt == ST_DISABLE) ? '0 : f_onehot(w_active_nxt);
        w_done_nxt   = w_req_noop || ((r_state == ST_ENABLE) && (w_state_nxt == ST_IDLE));
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_clk_en    <= '0;
            r_sel_ready <= 1'b0;
            r_switching <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_fb        <= 1'b0;
        end else begin
            r_clk_en    <= w_clk_en_nxt;
            r_sel_ready <= (w_state_nxt == ST_IDLE);
            r_switching <= (w_state_nxt != ST_IDLE);
            r_done      <= w_done_nxt;
            r_err       <= w_req_err;
            r_fb        <= w_start_fb;
        end
    end

    assign clk_en      = r_clk_en;
    assign sel_ready   = r_sel_ready;
    assign active_sel  = r_active;
    assign switching   = r_switching;
    assign done        = r_done;
    assign err_invalid = r_err;
    assign fallback    = r_fb;

endmodule
